fp_add_align_stage: RTL
=======================

FP_ADD_ALIGN_STAGE -- requirements
Module: fp_add_align_stage

Interface
REQ-001 Parameters: none; all widths fixed for FP32.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a  input  32  FP32 operand A (IEEE-754 binary32).
REQ-005 a_valid / a_ready  input / output  1 / 1  operand A handshake.
REQ-006 b  input  32  FP32 operand B.
REQ-007 b_valid / b_ready  input / output  1 / 1  operand B handshake.
REQ-008 out_valid / out_ready  output / input  1 / 1  aligned-pair handshake to the add stage.
REQ-009 out_special  output  1  result fully determined here; add stage passes out_result through.
REQ-010 out_result  output  32  final result when out_special=1, else 0.
REQ-011 out_sign  output  1  sign of larger-magnitude operand.
REQ-012 out_eff_sub  output  1  a[31]^b[31].
REQ-013 out_exp  output  8  biased effective exponent of the larger operand.
REQ-014 out_m_large / out_m_small  output  27 / 27  {hidden, frac[22:0], G, R, S}; small one aligned.

Function
REQ-015 Join: a_ready = b_valid && !full; b_ready = a_valid && !full; a pair transfers only when a_valid && b_valid && !full; partial presence never consumes either operand.
REQ-016 Latency: a pair accepted in cycle N appears with out_valid=1 in cycle N+1 when the buffer is empty; throughput one pair per cycle with out_ready=1.
REQ-017 Output buffering: two-entry skid buffer; full = both entries occupied; a_ready/b_ready depend only on registered state and the peer valid; no combinational out_ready-to-input-ready path.
REQ-018 Same-cycle push and pop when full: pop frees an entry; the push is accepted only if !full at the start of the cycle.
REQ-019 While out_valid && !out_ready, all out_* outputs hold stable; delivery order equals acceptance order; no drop, no duplication.
REQ-020 NaN: if either operand has exp=255 and frac!=0, out_special=1 and out_result=0x7FC00000.
REQ-021 Inf: +Inf plus -Inf gives 0x7FC00000; any other Inf operand gives signed Inf of that operand.
REQ-022 Zeros: both zero gives {a[31]&b[31], 31'b0}; exactly one zero passes the other operand bit-exact; all with out_special=1.
REQ-023 Otherwise out_special=0: subnormal (exp=0) uses effective exponent 1 and hidden bit 0; normal uses hidden bit 1; GRS bits start at 0.
REQ-024 Swap: larger = greater {exp, frac} magnitude; on equal magnitude A is larger.
REQ-025 Align: d = e_large - e_small (effective); out_m_small = m_small >> d, with the OR of all shifted-out bits ORed into bit 0; d >= 27 yields 27'd1 if m_small != 0, else 0.
REQ-026 When out_special=1, out_m_large, out_m_small, out_exp, out_sign and out_eff_sub are 0.

Reset
REQ-027 While rst_n=0: out_valid=0, a_ready=0, b_ready=0, all data outputs 0, buffer empty.
REQ-028 Reset asserted mid-operation discards all buffered pairs immediately (asynchronously); after release a_ready follows REQ-015 with full=0.

Structure
REQ-029 Shared package fp32_pkg holds FP32_QNAN=0x7FC00000, the field widths (1/8/23), MANT_W=27 and a packed struct fp_align_t carrying the out_* payload.
REQ-030 Buffering is a sub-module skid_buffer, parameterized by payload width and instantiated with $bits(fp_align_t); classification and alignment stay combinational in fp_add_align_stage.

Verification
REQ-031 a=0x3F800000, b=0x40000000, out_ready=1 -> next cycle out_valid=1, special=0, exp=0x80, m_large=0x4000000, m_small=0x2000000, eff_sub=0, sign=0.
REQ-032 a=0x7F800000, b=0xFF800000 -> out_special=1, out_result=0x7FC00000; a=0x7FA00000, b=0x3F800000 -> 0x7FC00000.
REQ-033 a=0x3F800000, b=0x00000001 -> special=0, exp=0x7F, m_large=0x4000000, m_small=27'd1.
REQ-034 out_ready=0, three back-to-back pairs -> two accepted, a_ready=b_ready=0 from the cycle after the second acceptance, outputs stable; out_ready=1 -> all three delivered in order.
REQ-035 a_valid=1, b_valid=0 for 3 cycles -> a_ready=0, nothing transferred; b_valid=1 -> exactly one pair transferred.
REQ-036 rst_n pulsed low with two entries buffered -> out_valid=0 during the low pulse, no stale entry delivered after release.

Source files
------------

// File: rtl/fp32_pkg.sv
// FP32 field widths, the canonical quiet NaN and the aligned-pair payload
// shared by the align stage and its output buffer.
package fp32_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              special;
    logic [31:0]       result;
    logic [SIGN_W-1:0] sign;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] m_large;
    logic [MANT_W-1:0] m_small;
  } fp_align_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry in-order buffer; ready depends only on registered occupancy so
// there is no combinational path from out_ready back to in_ready.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = slot0_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pop first so a push in the same cycle lands behind the surviving entry.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (pop) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) slot0_d = in_data;
      else               slot1_d = in_data;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/fp_add_align_stage.sv
// FP32 adder front end: joins the two operands, resolves special cases and
// aligns the smaller significand before handing the pair to the add stage.
module fp_add_align_stage
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       a,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [31:0]       b,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_special,
  output logic [31:0]       out_result,
  output logic              out_sign,
  output logic              out_eff_sub,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_m_large,
  output logic [MANT_W-1:0] out_m_small
);

  logic [EXP_W-1:0]  a_exp, b_exp, a_eexp, b_eexp, e_l, e_s, d;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic [MANT_W-1:0] a_m, b_m, m_l, m_s, m_sh, mask;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
  logic              buf_ready;
  fp_align_t         pay, buf_out;

  assign a_exp  = a[30:23];
  assign b_exp  = b[30:23];
  assign a_frac = a[22:0];
  assign b_frac = b[22:0];
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != '0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != '0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == '0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == '0);
  assign a_zero = (a[30:0] == '0);
  assign b_zero = (b[30:0] == '0);

  // Subnormals share the exponent of the smallest normal, without hidden bit.
  assign a_eexp = (a_exp == '0) ? 8'd1 : a_exp;
  assign b_eexp = (b_exp == '0) ? 8'd1 : b_exp;
  assign a_m    = {a_exp != '0, a_frac, 3'b000};
  assign b_m    = {b_exp != '0, b_frac, 3'b000};
  assign a_big  = (a[30:0] >= b[30:0]);

  always_comb begin
    pay  = '0;
    e_l  = a_big ? a_eexp : b_eexp;
    e_s  = a_big ? b_eexp : a_eexp;
    m_l  = a_big ? a_m : b_m;
    m_s  = a_big ? b_m : a_m;
    d    = e_l - e_s;
    mask = '0;
    m_sh = '0;
    if (d >= 8'd27) begin
      m_sh = (m_s != '0) ? 27'd1 : 27'd0;
    end else begin
      mask = (27'd1 << d[4:0]) - 27'd1;
      m_sh = (m_s >> d[4:0]) | {26'd0, |(m_s & mask)};
    end

    if (a_nan || b_nan) begin
      pay.special = 1'b1;
      pay.result  = FP32_QNAN;
    end else if (a_inf && b_inf) begin
      pay.special = 1'b1;
      pay.result  = (a[31] != b[31]) ? FP32_QNAN : a;
    end else if (a_inf || b_inf) begin
      pay.special = 1'b1;
      pay.result  = a_inf ? a : b;
    end else if (a_zero && b_zero) begin
      pay.special = 1'b1;
      pay.result  = {a[31] & b[31], 31'd0};
    end else if (a_zero || b_zero) begin
      pay.special = 1'b1;
      pay.result  = a_zero ? b : a;
    end else begin
      pay.sign    = a_big ? a[31] : b[31];
      pay.eff_sub = a[31] ^ b[31];
      pay.exp     = e_l;
      pay.m_large = m_l;
      pay.m_small = m_sh;
    end
  end

  // rst_n gating keeps both readies low throughout reset.
  assign a_ready = rst_n && b_valid && buf_ready;
  assign b_ready = rst_n && a_valid && buf_ready;

  skid_buffer #(.W($bits(fp_align_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid && b_valid),
    .in_data   (pay),
    .in_ready  (buf_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_special = buf_out.special;
  assign out_result  = buf_out.result;
  assign out_sign    = buf_out.sign;
  assign out_eff_sub = buf_out.eff_sub;
  assign out_exp     = buf_out.exp;
  assign out_m_large = buf_out.m_large;
  assign out_m_small = buf_out.m_small;

endmodule
